// File: rtl/enh_proc_pkg.sv
// enh_proc_pkg: shared fetch FSM state encodings and default widths
package enh_proc_pkg;
  typedef enum logic [1:0] {FS_IDLE, FS_RUN, FS_FLUSH} fetch_state_e;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 16;
endpackage

// File: rtl/inst_queue.sv
// inst_queue: shift-style tagged instruction FIFO; entry 0 is the head and holds its value when the queue empties
module inst_queue #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] push_tag,
  input  logic [DATA_W-1:0] push_data,
  output logic [CW-1:0]     count,
  output logic [ADDR_W-1:0] head_tag,
  output logic [DATA_W-1:0] head_data
);
  logic [ADDR_W+DATA_W-1:0] ent_q [DEPTH];
  logic [ADDR_W+DATA_W-1:0] ent_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d, widx;
  logic shift;
  // the last entry is never shifted out so the head keeps the last popped value
  always_comb begin
    widx = cnt_q - CW'(pop);
    shift = pop && !flush && cnt_q > CW'(1);
    for (int i = 0; i < DEPTH; i++)
      ent_d[i] = (push && !flush && CW'(i) == widx) ? {push_tag, push_data} :
                 (shift && i < DEPTH - 1) ? ent_q[(i + 1) % DEPTH] : ent_q[i];
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      ent_q <= ent_d;
    end
  end
  assign count = cnt_q;
  assign {head_tag, head_data} = ent_q[0];
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/fetch FSM with credit-based issue into a tagged queue; FETCH_STALL_CNT_EN adds stall_cycles
module fetch_sequencer
  import enh_proc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, fly_addr_q, fly_addr_d;
  logic fly_q, fly_d, pop, push;
  logic [CW-1:0] count;
  logic [OW-1:0] occ;
  // occupancy counts the in-flight read so a full queue can never be overrun
  always_comb begin
    pop = inst_valid & inst_ready;
    occ = {1'b0, count} + OW'(fly_q) - OW'(pop);
    mem_rd = (state_q == FS_RUN) & ~redirect & (occ < OW'(DEPTH));
    push = fly_q & ~redirect & (state_q != FS_FLUSH);
    state_d = redirect ? FS_FLUSH : run ? FS_RUN : FS_IDLE;
    pc_d = redirect ? redirect_addr : mem_rd ? pc_q + ADDR_W'(1) : pc_q;
    fly_d = mem_rd;
    fly_addr_d = mem_rd ? pc_q : fly_addr_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FS_IDLE;
      pc_q <= '0;
      fly_q <= 1'b0;
      fly_addr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      fly_q <= fly_d;
      fly_addr_q <= fly_addr_d;
    end
  end
  inst_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_tag  (fly_addr_q),
    .push_data (mem_q),
    .count     (count),
    .head_tag  (inst_pc),
    .head_data (inst_out)
  );
  assign inst_valid = count != '0;
  assign mem_addr = pc_q;
  assign pc_out = pc_q;
  assign busy = (state_q == FS_RUN) | fly_q | inst_valid;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb
    stall_d = (state_q == FS_RUN && !inst_valid && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk) begin
    if (!reset_n) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: vector table, redirect/wrap/idle/reset sequences, and a queue-level random model
module tb_fetch_sequencer;
  localparam int AW = 5, DW = 16, DEPTH = 2;
  logic clk = 0, reset_n = 0, run = 0, redirect = 0, inst_ready = 0;
  logic [AW-1:0] redirect_addr = '0, mem_addr, inst_pc, pc_out;
  logic [DW-1:0] mem_q = '0, inst_out;
  logic mem_rd, inst_valid, busy;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif
  logic [DW-1:0] mem [32];
  int tests = 0, fails = 0;

  fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .redirect(redirect), .redirect_addr(redirect_addr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_q(mem_q), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .pc_out(pc_out), .busy(busy)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_q <= mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; run = 0; redirect = 0; inst_ready = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  // redirect now; expects FLUSH, first read next cycle, first valid three samples later, then one per cycle
  task automatic redirect_seq(input logic [AW-1:0] addr);
    logic [AW-1:0] a;
    redirect = 1; redirect_addr = addr;
    @(negedge clk); redirect = 0; #1;
    chk("flush_valid", inst_valid, 0); chk("flush_rd", mem_rd, 0); chk("flush_addr", mem_addr, addr);
    @(negedge clk); #1;
    chk("redir_rd", mem_rd, 1); chk("redir_addr", mem_addr, addr); chk("redir_valid0", inst_valid, 0);
    @(negedge clk); #1;
    chk("redir_valid1", inst_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      a = addr + AW'(k);
      chk("redir_deliver_valid", inst_valid, 1); chk("redir_pc", inst_pc, a); chk("redir_data", inst_out, mem[a]);
    end
  endtask

  typedef struct {
    logic run, rdy;
    logic mrd; logic [AW-1:0] maddr; logic vld; logic [AW-1:0] ipc; logic [DW-1:0] iout; logic bsy;
  } vec_t;
  vec_t tbl[13];

  initial begin
    int n;
    int unsigned q_m[$];
    logic fly_m, running, exp_v, pop_m, exp_rd;
    logic [AW-1:0] fly_a, pc_m;
    for (int k = 0; k < 32; k++) mem[k] = 16'h1000 + 16'(k);
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 16'h0000, 0};
    tbl[1]  = '{1, 1, 1, 0, 0, 0, 16'h0000, 1};
    tbl[2]  = '{1, 1, 1, 1, 0, 0, 16'h0000, 1};
    tbl[3]  = '{1, 1, 1, 2, 1, 0, 16'h1000, 1};
    tbl[4]  = '{1, 0, 0, 3, 1, 1, 16'h1001, 1};
    tbl[5]  = '{1, 0, 0, 3, 1, 1, 16'h1001, 1};
    tbl[6]  = '{1, 0, 0, 3, 1, 1, 16'h1001, 1};
    tbl[7]  = '{1, 1, 1, 3, 1, 1, 16'h1001, 1};
    tbl[8]  = '{1, 1, 1, 4, 1, 2, 16'h1002, 1};
    tbl[9]  = '{0, 1, 1, 5, 1, 3, 16'h1003, 1};
    tbl[10] = '{0, 1, 0, 6, 1, 4, 16'h1004, 1};
    tbl[11] = '{0, 1, 0, 6, 1, 5, 16'h1005, 1};
    tbl[12] = '{0, 1, 0, 6, 0, 5, 16'h1005, 0};

    @(negedge clk); @(negedge clk); #1;
    chk("rst_valid", inst_valid, 0); chk("rst_rd", mem_rd, 0); chk("rst_addr", mem_addr, 0);
    chk("rst_out", inst_out, 0); chk("rst_pc", inst_pc, 0); chk("rst_busy", busy, 0);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      run = tbl[i].run; inst_ready = tbl[i].rdy; #1;
      chk($sformatf("vec%0d_rd", i), mem_rd, tbl[i].mrd);
      chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].maddr);
      chk($sformatf("vec%0d_valid", i), inst_valid, tbl[i].vld);
      chk($sformatf("vec%0d_pc", i), inst_pc, tbl[i].ipc);
      chk($sformatf("vec%0d_out", i), inst_out, tbl[i].iout);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
`ifdef FETCH_STALL_CNT_EN
      if (i == 3) chk("stall_cycles", stall_cycles, 2);
`endif
      @(negedge clk);
    end

    do_reset();
    run = 1; inst_ready = 1; #1;
    n = 0;
    while (!(mem_rd && mem_addr == 4) && n < 20) begin @(negedge clk); #1; n++; end
    chk("wait_addr4_timeout", n < 20, 1);
    @(negedge clk);
    redirect_seq(5'd20);
    redirect_seq(5'd30);

    run = 0; #1;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); #1; n++; end
    chk("drain_timeout", n < 20, 1);
    redirect = 1; redirect_addr = 5'd9;
    @(negedge clk); redirect = 0; #1;
    chk("idle_redir_busy", busy, 0); chk("idle_redir_rd", mem_rd, 0); chk("idle_redir_addr", mem_addr, 9);
    @(negedge clk); #1;
    chk("idle_after_flush_rd", mem_rd, 0); chk("idle_after_flush_addr", mem_addr, 9);
    run = 1;
    @(negedge clk); #1;
    chk("idle_restart_rd", mem_rd, 1); chk("idle_restart_addr", mem_addr, 9);
    repeat (3) @(negedge clk);
    reset_n = 0;
    @(negedge clk); #1;
    chk("midrst_valid", inst_valid, 0); chk("midrst_rd", mem_rd, 0); chk("midrst_addr", mem_addr, 0);
    chk("midrst_busy", busy, 0); chk("midrst_out", inst_out, 0); chk("midrst_pc", inst_pc, 0);
    reset_n = 1;

    for (int k = 0; k < 32; k++) mem[k] = 16'($urandom);
    do_reset();
    running = 0; fly_m = 0; fly_a = '0; pc_m = '0;
    q_m.delete();
    for (int c = 0; c < 800; c++) begin
      run = $urandom_range(0, 9) != 0;
      redirect = $urandom_range(0, 24) == 0;
      redirect_addr = AW'($urandom);
      inst_ready = $urandom_range(0, 3) != 0;
      #1;
      exp_v = q_m.size() > 0;
      pop_m = exp_v && inst_ready;
      exp_rd = running && !redirect && (q_m.size() + int'(fly_m) - int'(pop_m) < DEPTH);
      chk("rnd_rd", mem_rd, exp_rd);
      chk("rnd_addr", mem_addr, pc_m);
      chk("rnd_pc_out", pc_out, pc_m);
      chk("rnd_valid", inst_valid, exp_v);
      chk("rnd_busy", busy, running || fly_m || exp_v);
      if (exp_v) begin
        chk("rnd_inst_pc", inst_pc, q_m[0]);
        chk("rnd_inst_out", inst_out, mem[q_m[0]]);
      end
      if (pop_m) void'(q_m.pop_front());
      if (redirect) begin
        q_m.delete(); fly_m = 0; pc_m = redirect_addr;
      end else begin
        if (fly_m) q_m.push_back(fly_a);
        fly_m = exp_rd; fly_a = pc_m;
        if (exp_rd) pc_m = pc_m + AW'(1);
      end
      running = run && !redirect;
      @(negedge clk);
    end
    run = 0; redirect = 0; inst_ready = 1; #1;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); #1; n++; end
    chk("final_drain_timeout", n < 20, 1);
    chk("final_valid", inst_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer for the enhanced processor. It owns the program counter used to address the synchronous instruction memory, issues reads, absorbs the memory's one-cycle read latency in a small tagged queue, and hands instructions to the control-unit FSM over a valid/ready handshake. A redirect input reloads the fetch address and flushes stale instructions.

## Interface
- `ADDR_W`, 5 — instruction-memory address width; PC width.
- `DATA_W`, 16 — instruction width.
- `DEPTH`, 2 — instruction-queue entries. Counts in-flight reads. Minimum 2.

- `clk` in 1 — single clock. All state changes on the rising edge.
- `reset_n` in 1 — synchronous, active-low reset.
- `run` in 1 — fetch enable. Sampled each edge.
- `redirect` in 1 — load a new fetch address and flush.
- `redirect_addr` in ADDR_W — new fetch address.
- `mem_addr` out ADDR_W — instruction-memory address. Equals the PC, combinational.
- `mem_rd` out 1 — a read is issued this cycle. Data is returned on `mem_q` after the next edge.
- `mem_q` in DATA_W — instruction-memory read data.
- `inst_out` out DATA_W — head-of-queue instruction.
- `inst_pc` out ADDR_W — address that `inst_out` was fetched from.
- `inst_valid` out 1 — the queue head is valid.
- `inst_ready` in 1 — the control FSM accepts the head. A pop occurs on `inst_valid & inst_ready`.
- `pc_out` out ADDR_W — next fetch address.
- `busy` out 1 — high when the state is RUN, a read is in flight, or the queue is non-empty.
- `stall_cycles` out 16 — only present with `FETCH_STALL_CNT_EN`.

## Operation
- **FSM states:** IDLE, RUN, FLUSH.
  - IDLE → RUN on `run=1`.
  - RUN → IDLE on `run=0`.
  - Any state → FLUSH on `redirect=1`.
  - FLUSH → RUN if `run=1`, otherwise FLUSH → IDLE. FLUSH always lasts exactly one cycle.
- **Issue:** `mem_rd = (state==RUN) & ~redirect & (count + inflight - pop < DEPTH)`.
  - On issue, the PC increments modulo 2^ADDR_W, so 31 wraps to 0 at the default width.
  - `inflight` is set on issue and cleared on the following edge.
- **Capture:** on the edge after `mem_rd`, `mem_q` is pushed into the queue together with the issuing address. The capture is dropped if that edge is in FLUSH, or if `redirect` is asserted in the same cycle.
- **Redirect:**
  - The PC is set to `redirect_addr`.
  - The queue is emptied.
  - The in-flight read is discarded.
  - `redirect` has priority over issue and push.
  - A pop that is concurrent with `redirect` still completes: the consumer owns that instruction.
- **`run` deasserted:**
  - Issuing stops.
  - An in-flight read is still captured.
  - Queued entries remain deliverable.
  - The PC holds its value.
- **Redirect while IDLE:** the PC is updated and the queue flushed. The FSM passes through FLUSH, then returns to IDLE.
- **Queue behaviour:**
  - Full: issue is suppressed by the credit check above, so the queue can never overflow.
  - Empty: `inst_valid=0`. `inst_out` and `inst_pc` hold their last values.
- **Reset values:**
  - State IDLE, PC 0.
  - Queue empty, inflight 0.
  - `inst_valid=0`, `mem_rd=0`, `mem_addr=0`.
  - `inst_out=0`, `inst_pc=0`, `busy=0`, `stall_cycles=0`.
  - Reset mid-operation discards everything, including any in-flight read.

## Timing
- Latency:
  - `run` sampled high at edge E0 → `mem_rd=1`, `mem_addr=0` during the cycle after E0.
  - Data captured at E2 → `inst_valid=1` after E2.
- Throughput: with DEPTH ≥ 2 and `inst_ready` held high, one instruction is delivered per cycle.
- Redirect at edge E0:
  - FLUSH during cycle E0–E1.
  - First read of `redirect_addr` in cycle E1–E2.
  - Instruction valid after E3.
- Outputs `inst_*`, `busy`, and `stall_cycles` are registered. `mem_rd` and `mem_addr` are combinational from registers.

## Configuration
- `FETCH_STALL_CNT_EN` defined:
  - `stall_cycles` counts cycles with state RUN and `inst_valid=0`.
  - The count saturates at 0xFFFF.
  - It is cleared only by reset.
- `FETCH_STALL_CNT_EN` undefined: the port and the counter are absent, and there is no other behavioural change.

## Structure
- Shared package `enh_proc_pkg`:
  - FSM state encodings `FS_IDLE`, `FS_RUN`, `FS_FLUSH`.
  - Default `ADDR_W` and `DATA_W` constants.
- Sub-module `inst_queue`: a synchronous FIFO of DEPTH entries, each {ADDR_W tag, DATA_W instruction}.
  - Ports: push, pop, flush, count, and head.
  - Flush has priority over push.
- The FSM, PC, credit logic, and stall counter live in `fetch_sequencer`.

## Test plan
- **Reset then run:** reset, hold `run=1`, `inst_ready=1`, memory word k = 0x1000+k → `mem_rd` in cycle 1 with address 0; instruction 0x1000 with `inst_pc=0` valid after edge 2; then 0x1001, 0x1002, … one per cycle.
- **Back-pressure:** `inst_ready=0` from cycle 3 → at most DEPTH entries are held; `mem_rd` stays low; releasing `inst_ready` delivers entries in order with no loss or duplicate.
- **Redirect:** `redirect=1` with `redirect_addr=20` while a read of address 4 is in flight → address 4 is never delivered; the next `inst_pc` values are 20, 21, ….
- **Wrap-around:** redirect to 30 → `inst_pc` sequence 30, 31, 0, 1.
- **Run drop:** `run=0` with one read in flight → the in-flight read is captured and delivered, no further `mem_rd`, and `busy` falls after the queue drains.
- **Stall counter:** with `FETCH_STALL_CNT_EN`, hold `inst_ready=1` and run from reset → `stall_cycles=2` after the first instruction.
